// File: rtl/reg_file_param.sv
// Parametrised register file for the decode stage.
// - Two combinational read ports and one synchronous write port.
// - Optional hardwired zero register and optional write-first bypass.
// - Per-register pending-write scoreboard for hazard checks.
// - Handshaked dump engine that streams every register out in order.
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              rs_pending,
  output logic              rt_pending,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  // Dump handshake: a word moves on a rising edge where dump_valid and
  // dump_ready are both 1; while valid is high and ready is low, dump_addr
  // and dump_data stay unchanged. dump_valid never depends on dump_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } dump_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  // Observable copy of the dump FSM state for checkers.
  dump_state_e       dump_state;
  assign dump_state = state_q;

  logic wr_ok;
  logic rs_hit, rt_hit;
  assign wr_ok  = wr_en && !(ZERO_EN && (wr_addr == '0));
  assign rs_hit = BYP_EN && wr_en && (wr_addr == rs_addr);
  assign rt_hit = BYP_EN && wr_en && (wr_addr == rt_addr);

  // Next register contents and scoreboard; a mark beats a same-cycle write.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
    if (wr_en) pend_d[wr_addr] = 1'b0;
    if (mark_en) pend_d[mark_addr] = 1'b1;
    if (ZERO_EN) pend_d[0] = 1'b0;
  end

  // Read port A: zero register, then bypass, then array.
  always_comb begin
    rs_data = mem_q[rs_addr];
    if (ZERO_EN && (rs_addr == '0)) rs_data = '0;
    else if (rs_hit) rs_data = wr_data;
  end

  // Read port B: same priority as port A.
  always_comb begin
    rt_data = mem_q[rt_addr];
    if (ZERO_EN && (rt_addr == '0)) rt_data = '0;
    else if (rt_hit) rt_data = wr_data;
  end

  // Pending flags; a write landing this cycle resolves the hazard via bypass.
  always_comb begin
    rs_pending = pend_q[rs_addr] && !rs_hit;
    rt_pending = pend_q[rt_addr] && !rt_hit;
  end

  // Dump FSM next state; LOAD samples the array before this cycle's write.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        dump_addr_d = idx_q;
        dump_data_d = (ZERO_EN && (idx_q == '0)) ? '0 : mem_q[idx_q];
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dump_valid = (state_q == S_SEND);
  assign dump_busy  = (state_q != S_IDLE);
  assign dump_done  = (state_q == S_DONE);
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q      <= '0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      pend_q      <= pend_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed vectors, a behavioural model of the
// register file, scoreboard and dump stream, and per-cycle comparison.
module tb_reg_file_param;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wr_en, mark_en, dump_start, dump_ready;
  logic [AW-1:0] wr_addr, rs_addr, rt_addr, mark_addr, dump_addr;
  logic [DW-1:0] wr_data, rs_data, rt_data, dump_data;
  logic          rs_pending, rt_pending, dump_valid, dump_busy, dump_done;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .rs_pending(rs_pending), .rt_pending(rt_pending),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    m_mem [N];
  bit               m_pend [N];
  bit               m_in_dump, m_load, m_done;
  int               m_left;
  logic [AW+DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    return m_pend[a] && !(wr_en && wr_addr == a);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
      m_in_dump = 1'b0; m_load = 1'b0; m_done = 1'b0; m_left = 0;
      exp_q.delete();
    end else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
      if (!m_in_dump) begin
        if (dump_start) begin
          m_in_dump = 1'b1; m_load = 1'b1; m_left = N;
          for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), m_mem[i]});
        end
      end else if (m_done) begin
        m_in_dump = 1'b0; m_done = 1'b0;
      end else if (m_load) begin
        m_load = 1'b0;
      end else if (dump_ready) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
        else m_load = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  int            xfer_total = 0;
  int            done_count = 0;
  logic [DW-1:0] obs_data [N];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rs_data", rs_data, exp_read(rs_addr));
      chk("rt_data", rt_data, exp_read(rt_addr));
      chk("rs_pending", rs_pending, exp_pend(rs_addr));
      chk("rt_pending", rt_pending, exp_pend(rt_addr));
      chk("dump_busy", dump_busy, m_in_dump);
      chk("dump_done", dump_done, m_done);
      chk("dump_valid", dump_valid, m_in_dump && !m_load && !m_done);
      if (dump_done) done_count++;
      if (m_in_dump && !m_load && !m_done) begin
        if (exp_q.size() == 0) begin
          chk("dump_queue_empty", 32'd0, 32'd1);
        end else begin
          chk("dump_addr", dump_addr, exp_q[0][AW+DW-1:DW]);
          chk("dump_data", dump_data, exp_q[0][DW-1:0]);
          if (dump_ready) begin
            obs_data[dump_addr] = dump_data;
            void'(exp_q.pop_front());
            xfer_total++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; rs_addr = 0; rt_addr = 0;
    mark_en = 0; mark_addr = 0; dump_start = 0; dump_ready = 0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      rs_addr = AW'(i); rt_addr = AW'(N - 1 - i);
      @(negedge clk);
      chk({tag, "_rs"}, rs_data, 32'h0);
      chk({tag, "_rt"}, rt_data, 32'h0);
      tick();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    bit seen;
    idle_inputs();
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;

    // reset state
    @(negedge clk);
    chk("rst_busy", dump_busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_dump_addr", dump_addr, 0);
    chk("rst_dump_data", dump_data, 0);
    read_all_zero("rst_read");

    // write/readback and zero register
    write(5, 16'hBEEF);
    write(0, 16'h1234);
    rs_addr = 5; rt_addr = 0;
    @(negedge clk);
    chk("r5_readback", rs_data, 16'hBEEF);
    chk("r0_zero", rt_data, 16'h0000);
    tick();

    // bypass
    write(7, 16'h0001);
    wr_en = 1; wr_addr = 7; wr_data = 16'hA5A5; rs_addr = 7; rt_addr = 7;
    @(negedge clk);
    chk("bypass_rs", rs_data, 16'hA5A5);
    chk("bypass_rt", rt_data, 16'hA5A5);
    tick();
    wr_en = 0;

    // scoreboard: mark, wait, write
    rs_addr = 3; rt_addr = 3;
    mark_en = 1; mark_addr = 3;
    tick();
    mark_en = 0;
    @(negedge clk);
    chk("pend_after_mark", rs_pending, 1);
    tick();
    wr_en = 1; wr_addr = 3; wr_data = 16'h0042;
    @(negedge clk);
    chk("pend_write_bypass", rs_pending, 0);
    chk("r3_bypass", rs_data, 16'h0042);
    tick();
    wr_en = 0;
    @(negedge clk);
    chk("pend_cleared", rs_pending, 0);

    // simultaneous mark and write: mark wins
    mark_en = 1; mark_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 16'h0055;
    tick();
    mark_en = 0; wr_en = 0;
    @(negedge clk);
    chk("pend_mark_wins", rs_pending, 1);
    chk("r3_written", rs_data, 16'h0055);
    write(3, 16'h0055);

    // register 0 is never pending
    mark_en = 1; mark_addr = 0; rs_addr = 0;
    tick();
    mark_en = 0;
    @(negedge clk);
    chk("r0_never_pending", rs_pending, 0);

    // preload and dump with backpressure
    for (int i = 1; i < N; i++) write(AW'(i), 16'h0100 + 16'(i));
    dump_ready = 1;
    dump_start = 1;
    tick();
    dump_start = 0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      dump_ready = (k % 2 == 0);
      dump_start = (k == 10);
      tick();
      if (done_count > 0) seen = 1;
    end
    dump_start = 0;
    chk("dump_finished", seen, 1);
    tick(); tick(); tick();
    chk("dump_done_once", done_count, 1);
    chk("dump_xfers", xfer_total, 16);
    chk("dump_word0", obs_data[0], 16'h0000);
    chk("dump_word1", obs_data[1], 16'h0101);
    chk("dump_word15", obs_data[15], 16'h010F);
    @(negedge clk);
    chk("dump_idle_after", dump_busy, 0);

    // reset mid-dump
    base = xfer_total;
    dump_ready = 1;
    dump_start = 1;
    tick();
    dump_start = 0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (xfer_total >= base + 5) seen = 1;
    end
    chk("mid_dump_reached", seen, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    dump_ready = 0;
    @(negedge clk);
    chk("abort_valid", dump_valid, 0);
    chk("abort_busy", dump_busy, 0);
    chk("abort_dump_addr", dump_addr, 0);
    read_all_zero("abort_read");
    chk("abort_no_done", done_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 16x16 register file. Two combinational read ports, one synchronous write port.
- Adds: optional hardwired zero register, optional write-first bypass, full clear on reset, and a per-register pending-write scoreboard for pipeline hazard checks.
- Adds a handshaked debug dump engine that streams every register out in order.
- Sits in the decode stage between instruction decode and the ALU operand muxes. The dump port connects to the test/debug harness.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width. DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1. When 1, register 0 always reads 0, ignores writes and is never pending.
- BYPASS, 1. When 1, a same-cycle write to the read address is forwarded to the read data.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- mark_en  in  1  mark a register as awaiting a write.
- mark_addr  in  ADDR_W  register to mark.
- rs_pending  out  1  register at rs_addr awaits a write.
- rt_pending  out  1  register at rt_addr awaits a write.
- dump_start  in  1  request a full register dump.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the dump word.
- dump_addr  out  ADDR_W  index of the current dump word.
- dump_data  out  DATA_W  current dump word.
- dump_busy  out  1  dump engine not idle.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:

Reset:
- Clock is clk; reset is rst_n, synchronous, active-low.
- While rst_n=0 at a clk edge:
  - all DEPTH registers are set to 0;
  - all pending bits are cleared;
  - the dump FSM goes to IDLE with index 0;
  - dump_valid, dump_busy, dump_done, dump_addr and dump_data are 0.
- Reset asserted mid-dump aborts the dump. No dump_done is issued.

Write:
- At a clk edge with wr_en=1, mem[wr_addr] <= wr_data.
- With ZERO_REG=1, a write to address 0 is dropped.

Read (combinational, zero latency), per port:
- If ZERO_REG=1 and the address is 0, output 0.
- Else if BYPASS=1, wr_en=1 and wr_addr equals the read address, output wr_data.
- Otherwise output mem[address].
- Both ports may read the same address.

Scoreboard:
- pend[DEPTH] bits.
- mark_en=1 sets pend[mark_addr]; wr_en=1 clears pend[wr_addr].
- Mark and write to the same address in the same cycle: the mark wins and the bit ends up 1.
- Marking an already-pending register has no effect.
- With ZERO_REG=1, pend[0] stays 0.
- rs_pending = pend[rs_addr] AND NOT (BYPASS AND wr_en AND wr_addr==rs_addr). rt_pending follows the same rule.

Dump FSM (states IDLE, LOAD, SEND, DONE):
- IDLE: dump_start=1 moves to LOAD with index 0. dump_busy=1 in every state except IDLE. dump_start is ignored outside IDLE.
- LOAD (1 cycle):
  - dump_data <= register value at index, with the zero-register rule applied and no bypass;
  - a write to the same index in this cycle is not captured;
  - dump_addr <= index; go to SEND.
- SEND:
  - dump_valid=1;
  - dump_data and dump_addr are held stable until dump_valid AND dump_ready;
  - on transfer: if index==DEPTH-1, go to DONE; else index++ and go to LOAD.
- DONE (1 cycle): dump_done=1, dump_valid=0, then IDLE.
- Minimum dump duration is 2*DEPTH+1 cycles from the start edge to the dump_done cycle.
- Normal writes, reads and scoreboard updates continue during a dump.

Test Plan:
- Reset then reads: hold rst_n=0 for 2 cycles, release, read all 16 addresses -> every rs_data and rt_data is 0x0000; rs_pending, rt_pending and dump_busy are 0.
- Write/readback and zero register: write 0xBEEF to r5, then 0x1234 to r0 -> next cycle r5 reads 0xBEEF and r0 reads 0x0000.
- Bypass: r7 holds 0x0001; drive wr_en=1, wr_addr=7, wr_data=0xA5A5 with rs_addr=rt_addr=7 in the same cycle -> both outputs show 0xA5A5 combinationally.
- Scoreboard:
  - mark r3, then 2 cycles later write r3=0x0042 -> rs_pending(3)=1 from the mark edge until the write cycle, where it reads 0 through bypass; the pend bit is cleared after the write edge.
  - Simultaneous mark and write of r3 -> pend bit stays 1.
- Dump with backpressure:
  - preload r_i = 0x0100+i for i=1..15;
  - start the dump with dump_ready toggling 1,0,1,0;
  - expected: 16 transfers in order, dump_addr 0..15, data 0x0000, 0x0101..0x010F, each word stable across stalls;
  - dump_done pulses once; a dump_start issued mid-dump is ignored.
- Reset mid-dump: drop rst_n after 5 transfers -> next cycle dump_valid=0 and dump_busy=0, no dump_done, registers are 0.
